filter_out_decim: RTL

- Output stage directly downstream of the transposed FIR filter.
- Consumes the filter's 18-bit samples on Data_i/DataNd_i and keeps one sample in every DECIM.
- Reduces each kept sample to OUT_W bits and buffers it in a small FIFO.
- Delivers buffered samples to the next block with a valid/ready handshake, so the filter never has to stall.

---
 rtl/filter_out_decim.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/filter_out_decim.sv
// Decimating output stage for the transposed FIR: keeps one strobe in DECIM, reduces it to OUT_W bits
// and buffers it in a show-ahead FIFO. Define FILTER_OUT_DECIM_ROUND_EN for convergent rounding with saturation.
module filter_out_decim #(
  parameter int IN_W       = 18,
  parameter int OUT_W      = 16,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Clk_i,
  input  logic                          Rst_i,
  input  logic [IN_W-1:0]               Data_i,
  input  logic                          DataNd_i,
  input  logic                          Sync_i,
  output logic [OUT_W-1:0]              Data_o,
  output logic                          DataValid_o,
  input  logic                          DataReady_i,
  output logic                          Overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   Level_o
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = IN_W - OUT_W;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [LW-1:0] DEPTH_L    = LW'(FIFO_DEPTH);

  logic [PW-1:0]    phase_r;
  logic [PW-1:0]    phase_next_s;
  logic             keep_s;
  logic [OUT_W-1:0] red_s;
  logic [OUT_W-1:0] red_r;
  logic             red_vld_r;

  logic [OUT_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_next_s;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_next_s;
  logic             pop_s;
  logic             full_s;
  logic             accept_s;
  logic             ovf_r;
  logic             valid_r;
  logic [OUT_W-1:0] data_r;
  logic [OUT_W-1:0] data_next_s;

  // Phase tracking: Sync_i with a strobe keeps that strobe and treats it as phase 0.
  always_comb begin
    keep_s       = DataNd_i && (Sync_i || (phase_r == PW'(0)));
    phase_next_s = phase_r;
    if (DataNd_i) begin
      if (Sync_i) begin
        phase_next_s = (DECIM == 1) ? PW'(0) : PW'(1);
      end else if (phase_r == PHASE_LAST) begin
        phase_next_s = PW'(0);
      end else begin
        phase_next_s = phase_r + PW'(1);
      end
    end else if (Sync_i) begin
      phase_next_s = PW'(0);
    end else begin
      phase_next_s = phase_r;
    end
  end

  generate
    if (DW == 0) begin : g_pass
      assign red_s = Data_i;
    end else begin : g_reduce
`ifdef FILTER_OUT_DECIM_ROUND_EN
      localparam logic [DW-1:0]    HALF    = DW'(1) << (DW - 1);
      localparam logic [OUT_W-1:0] MAX_POS = ~(OUT_W'(1) << (OUT_W - 1));
      logic [OUT_W-1:0] kept_s;
      logic [DW-1:0]    frac_s;
      logic             up_s;

      // Round half to even; only the largest positive value can overflow when rounded up.
      always_comb begin
        kept_s = Data_i[IN_W-1:DW];
        frac_s = Data_i[DW-1:0];
        up_s   = (frac_s > HALF) || ((frac_s == HALF) && kept_s[0]);
        if (up_s && (kept_s == MAX_POS)) begin
          red_s = MAX_POS;
        end else begin
          red_s = kept_s + OUT_W'(up_s);
        end
      end
`else
      logic unused_lsb_s;
      assign unused_lsb_s = ^Data_i[DW-1:0];
      assign red_s        = Data_i[IN_W-1:DW];
`endif
    end
  endgenerate

  // FIFO control; the head register tracks the entry that will be at the front after this edge.
  always_comb begin
    pop_s         = (level_r != LW'(0)) && DataReady_i;
    full_s        = (level_r == DEPTH_L);
    accept_s      = red_vld_r && (!full_s || pop_s);
    rd_ptr_next_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    case ({accept_s, pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
    if (level_next_s == LW'(0)) begin
      data_next_s = data_r;
    end else if (level_r == LW'(pop_s)) begin
      data_next_s = red_r;
    end else begin
      data_next_s = mem_r[rd_ptr_next_s];
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      phase_r   <= PW'(0);
      red_r     <= OUT_W'(0);
      red_vld_r <= 1'b0;
      wr_ptr_r  <= AW'(0);
      rd_ptr_r  <= AW'(0);
      level_r   <= LW'(0);
      ovf_r     <= 1'b0;
      valid_r   <= 1'b0;
      data_r    <= OUT_W'(0);
    end else begin
      phase_r   <= phase_next_s;
      red_vld_r <= keep_s;
      if (keep_s) begin
        red_r <= red_s;
      end
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_next_s;
      level_r  <= level_next_s;
      if (red_vld_r && !accept_s) begin
        ovf_r <= 1'b1;
      end
      valid_r <= (level_next_s != LW'(0));
      data_r  <= data_next_s;
    end
  end

  // Storage needs no reset: occupancy and the head register define what is visible.
  always_ff @(posedge Clk_i) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= red_r;
    end
  end

  assign Data_o      = data_r;
  assign DataValid_o = valid_r;
  assign Level_o     = level_r;
  assign Overflow_o  = ovf_r;

endmodule
